br_commit_queue: RTL and testbench

Commit-side producer for the branch predictor's update port. It accepts up to two committed instructions per cycle from the ROB head and buffers the branch outcomes in an in-order FIFO. It drains one outcome per cycle onto the predictor's `ena`/`hit`/`pc` update interface. It also raises a registered rollback request on the first mispredicted branch and keeps branch and mispredict statistics.

---
 rtl/br_commit_queue_pkg.sv | 24 ++
 rtl/br_fifo.sv | 67 ++++++
 rtl/br_commit_queue.sv | 120 ++++++++++++
 tb/tb_br_commit_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/br_commit_queue_pkg.sv
// Shared types and constants for the branch-outcome commit queue.
//   BRQ_DEPTH     default number of queued outcomes
//   addr_t        32-bit instruction address
//   br_entry_t    one queued outcome {pc, taken}
//   rb_target()   correct fetch PC after a mispredicted conditional branch
package br_commit_queue_pkg;

  localparam int BRQ_DEPTH = 8;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    addr_t pc;
    logic  taken;
  } br_entry_t;

  // Taken branches resume at the resolved target, not-taken ones at the
  // fall-through address; the +4 wraps modulo 2^32 by construction.
  function automatic addr_t rb_target(input addr_t pc, input logic taken,
                                      input addr_t target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_fifo.sv
// In-order FIFO with two write ports and one read port.
//   clk, rst            clock, synchronous active-high reset
//   wr0_en/wr0_data     older write; lands first when both ports write
//   wr1_en/wr1_data     younger write
//   rd_en               pop the head this cycle (ignored when empty)
//   rd_data             current head entry (undefined when count is 0)
//   count               number of valid entries, 0..DEPTH
// The caller guarantees at most DEPTH-count writes per cycle; there is no
// overflow protection inside.
module br_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0_en,
  input  logic [W-1:0]  wr0_data,
  input  logic          wr1_en,
  input  logic [W-1:0]  wr1_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;
  logic [W-1:0]  first_data;

  assign pop     = rd_en && (count_q != '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    // A lone slot-1 write still occupies the next free location.
    first_data = wr0_en ? wr0_data : wr1_data;
    wr_ptr_d   = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
  end

  // Storage carries no reset; stale contents are never visible because the
  // consumer gates its outputs on count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0_en || wr1_en) mem_q[wr_ptr_q] <= first_data;
      if (wr0_en && wr1_en) mem_q[wr_ptr_q + AW'(1)] <= wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/br_commit_queue.sv
// Commit-side producer for the branch predictor update port.
//   clk, rst                 clock, synchronous active-high reset
//   cm0_* / cm1_*            two commit slots from the ROB head (slot 0 oldest):
//                            valid, is_br, pc, taken, pred, target
//   commit_ready             ROB may commit this cycle (room for two pushes)
//   ena_to_bp/hit_to_bp/pc_to_bp  one branch outcome per cycle to the predictor
//   rollback/rollback_pc     one-cycle flush request and correct fetch PC
//   br_total/br_miss         committed branch / mispredict statistics
//
// Handshake: a commit slot transfers on a cycle where its valid and
// commit_ready are both high; valid while commit_ready is low is dropped.
// The predictor side has no ready: the head is popped in every cycle that
// ena_to_bp is high.
module br_commit_queue
  import br_commit_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cm0_valid,
  input  logic             cm0_is_br,
  input  logic [31:0]      cm0_pc,
  input  logic             cm0_taken,
  input  logic             cm0_pred,
  input  logic [31:0]      cm0_target,
  input  logic             cm1_valid,
  input  logic             cm1_is_br,
  input  logic [31:0]      cm1_pc,
  input  logic             cm1_taken,
  input  logic             cm1_pred,
  input  logic [31:0]      cm1_target,
  output logic             commit_ready,
  output logic             ena_to_bp,
  output logic             hit_to_bp,
  output logic [31:0]      pc_to_bp,
  output logic             rollback,
  output logic [31:0]      rollback_pc,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_miss
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $bits(br_entry_t);

  logic [CW-1:0]    count;
  logic             push0, push1;
  logic             mis0, mis1;
  br_entry_t        entry0, entry1, head;
  logic [EW-1:0]    head_raw;

  logic             rollback_q, rollback_d;
  addr_t            rollback_pc_q, rollback_pc_d;
  logic [CNT_W-1:0] br_total_q, br_total_d;
  logic [CNT_W-1:0] br_miss_q, br_miss_d;

  // count <= DEPTH-2 leaves room for a worst-case double push.
  assign commit_ready = (count <= CW'(DEPTH - 2));

  always_comb begin
    push0 = cm0_valid && cm0_is_br && commit_ready;
    mis0  = push0 && (cm0_taken != cm0_pred);
    // Slot 1 is on the wrong path once slot 0 mispredicts.
    push1 = cm1_valid && cm1_is_br && commit_ready && !mis0;
    mis1  = push1 && (cm1_taken != cm1_pred);
    entry0 = '{pc: cm0_pc, taken: cm0_taken};
    entry1 = '{pc: cm1_pc, taken: cm1_taken};
  end

  br_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (push0),
    .wr0_data (entry0),
    .wr1_en   (push1),
    .wr1_data (entry1),
    .rd_en    (ena_to_bp),
    .rd_data  (head_raw),
    .count    (count)
  );

  assign head      = head_raw;
  assign ena_to_bp = (count != '0);
  assign hit_to_bp = ena_to_bp && head.taken;
  assign pc_to_bp  = ena_to_bp ? head.pc : 32'd0;

  always_comb begin
    rollback_d    = mis0 || mis1;
    rollback_pc_d = rollback_pc_q;
    if (mis0)      rollback_pc_d = rb_target(cm0_pc, cm0_taken, cm0_target);
    else if (mis1) rollback_pc_d = rb_target(cm1_pc, cm1_taken, cm1_target);
    br_total_d = br_total_q + CNT_W'(push0) + CNT_W'(push1);
    br_miss_d  = br_miss_q + CNT_W'(mis0 || mis1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rollback_q    <= 1'b0;
      rollback_pc_q <= '0;
      br_total_q    <= '0;
      br_miss_q     <= '0;
    end else begin
      rollback_q    <= rollback_d;
      rollback_pc_q <= rollback_pc_d;
      br_total_q    <= br_total_d;
      br_miss_q     <= br_miss_d;
    end
  end

  assign rollback    = rollback_q;
  assign rollback_pc = rollback_pc_q;
  assign br_total    = br_total_q;
  assign br_miss     = br_miss_q;

endmodule

// File: tb/tb_br_commit_queue.sv
module tb_br_commit_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             cm0_valid = 0, cm0_is_br = 0, cm0_taken = 0, cm0_pred = 0;
  logic [31:0]      cm0_pc = 0, cm0_target = 0;
  logic             cm1_valid = 0, cm1_is_br = 0, cm1_taken = 0, cm1_pred = 0;
  logic [31:0]      cm1_pc = 0, cm1_target = 0;
  logic             commit_ready, ena_to_bp, hit_to_bp, rollback;
  logic [31:0]      pc_to_bp, rollback_pc;
  logic [CNT_W-1:0] br_total, br_miss;

  br_commit_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cm0_valid(cm0_valid), .cm0_is_br(cm0_is_br), .cm0_pc(cm0_pc),
    .cm0_taken(cm0_taken), .cm0_pred(cm0_pred), .cm0_target(cm0_target),
    .cm1_valid(cm1_valid), .cm1_is_br(cm1_is_br), .cm1_pc(cm1_pc),
    .cm1_taken(cm1_taken), .cm1_pred(cm1_pred), .cm1_target(cm1_target),
    .commit_ready(commit_ready), .ena_to_bp(ena_to_bp), .hit_to_bp(hit_to_bp),
    .pc_to_bp(pc_to_bp), .rollback(rollback), .rollback_pc(rollback_pc),
    .br_total(br_total), .br_miss(br_miss)
  );

  // ---------------- scoreboard ----------------
  logic [32:0]      exp_q[$];   // {pc, taken} in drain order
  logic             exp_rb = 0;
  logic [31:0]      exp_rb_pc = 0;
  logic [CNT_W-1:0] exp_total = 0, exp_miss = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [32:0] hd;
    chk("ena_to_bp", 64'(ena_to_bp), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      hd = exp_q[0];
      chk("pc_to_bp", 64'(pc_to_bp), 64'(hd[32:1]));
      chk("hit_to_bp", 64'(hit_to_bp), 64'(hd[0]));
    end else begin
      chk("pc_to_bp_empty", 64'(pc_to_bp), 64'd0);
      chk("hit_to_bp_empty", 64'(hit_to_bp), 64'd0);
    end
    chk("commit_ready", 64'(commit_ready), 64'(exp_q.size() <= DEPTH - 2));
    chk("rollback", 64'(rollback), 64'(exp_rb));
    chk("rollback_pc", 64'(rollback_pc), 64'(exp_rb_pc));
    chk("br_total", 64'(br_total), 64'(exp_total));
    chk("br_miss", 64'(br_miss), 64'(exp_miss));
  endtask

  // ---------------- driver ----------------
  // Checks the state left by the previous edge, applies one cycle of commit
  // inputs, advances the model across the coming edge, then clocks.
  task automatic step(input logic v0, b0, input logic [31:0] pc0,
                      input logic t0, p0, input logic [31:0] tg0,
                      input logic v1, b1, input logic [31:0] pc1,
                      input logic t1, p1, input logic [31:0] tg1);
    logic rdy, q0, q1, m0, m1;
    check_outputs();
    cm0_valid = v0; cm0_is_br = b0; cm0_pc = pc0; cm0_taken = t0; cm0_pred = p0; cm0_target = tg0;
    cm1_valid = v1; cm1_is_br = b1; cm1_pc = pc1; cm1_taken = t1; cm1_pred = p1; cm1_target = tg1;
    rdy = (exp_q.size() <= DEPTH - 2);
    q0  = v0 && b0 && rdy;
    m0  = q0 && (t0 != p0);
    q1  = v1 && b1 && rdy && !m0;
    m1  = q1 && (t1 != p1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (q0) exp_q.push_back({pc0, t0});
    if (q1) exp_q.push_back({pc1, t1});
    exp_rb = m0 || m1;
    if (m0)      exp_rb_pc = t0 ? tg0 : pc0 + 32'd4;
    else if (m1) exp_rb_pc = t1 ? tg1 : pc1 + 32'd4;
    exp_total = exp_total + CNT_W'(q0) + CNT_W'(q1);
    exp_miss  = exp_miss + CNT_W'(m0 || m1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,0,0, 0,0,0,0,0,0);
  endtask

  // Reset while the given commit slots are presented; reset wins.
  task automatic reset_with_push(input logic v);
    rst = 1'b1;
    cm0_valid = v; cm0_is_br = v; cm0_pc = 32'h900; cm0_taken = 1; cm0_pred = 0;
    cm1_valid = v; cm1_is_br = v; cm1_pc = 32'h904; cm1_taken = 0; cm1_pred = 0;
    exp_q.delete();
    exp_rb = 0; exp_rb_pc = 0; exp_total = 0; exp_miss = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] pc_seq;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then single push.
    step(1,1,32'h100,1,1,32'h0, 0,0,0,0,0,0);
    idle(3);

    // Dual push, drain order.
    step(1,1,32'h200,0,0,32'h0, 1,1,32'h204,1,1,32'h0);
    idle(3);

    // Slot-0 mispredict discards slot 1.
    step(1,1,32'h300,1,0,32'h40, 1,1,32'h304,1,1,32'h500);
    idle(3);

    // Slot-1 not-taken mispredict at the address wrap.
    step(1,1,32'h400,0,0,32'h0, 1,1,32'hFFFF_FFFC,0,1,32'h1234);
    idle(3);

    // Non-branch commits are ignored.
    step(1,0,32'h600,1,0,32'h80, 1,0,32'h604,0,1,32'h0);
    idle(1);

    // Full: dual commit every cycle, including while commit_ready is low.
    pc_seq = 32'h1000;
    for (int i = 0; i < 14; i++) begin
      step(1,1,pc_seq,i[0],i[0],32'h0, 1,1,pc_seq + 32'd4,~i[0],~i[0],32'h0);
      pc_seq = pc_seq + 32'd8;
    end
    idle(DEPTH + 2);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0,1), $urandom_range(0,1), $urandom() & 32'hFFFF_FFFC,
           $urandom_range(0,1), $urandom_range(0,1), $urandom(),
           $urandom_range(0,1), $urandom_range(0,1), $urandom() & 32'hFFFF_FFFC,
           $urandom_range(0,1), $urandom_range(0,1), $urandom());
    end
    idle(DEPTH + 2);

    // Reset mid-operation with five entries queued and a push presented.
    pc_seq = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      step(1,1,pc_seq,1,1,32'h0, 1,1,pc_seq + 32'd4,0,0,32'h0);
      pc_seq = pc_seq + 32'd8;
    end
    step(1,1,32'h3000,1,0,32'h3300, 0,0,0,0,0,0);
    reset_with_push(1'b1);
    idle(3);

    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
